// File: rtl/sd_interp_x128.sv
// sd_interp_x128: PCM sample FIFO plus linear interpolator feeding the sigma-delta
// modulator. One interpolated sample per clock; a new input sample is consumed every
// OSR clocks at the segment boundary.
module sd_interp_x128 #(
    parameter int unsigned OSR        = 128,
    parameter int unsigned OSR_LOG2   = 7,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_sample,
    output logic        out_valid,
    output logic        frame_tick,
    output logic        underrun,
    output logic [7:0]  underrun_cnt
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ACC_W = 16 + OSR_LOG2;
    localparam logic [CNT_W-1:0]    DEPTH_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [OSR_LOG2-1:0] PHASE_LAST = OSR_LOG2'(OSR - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                  state_q, state_d;
    logic [15:0]             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    in_ready_q, in_ready_d;
    logic [OSR_LOG2-1:0]     phase_q, phase_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [15:0]             cur_q, cur_d;
    logic signed [16:0]      delta_q, delta_d;
    logic                    frame_tick_q, frame_tick_d;
    logic                    underrun_q, underrun_d;
    logic [7:0]              ucnt_q, ucnt_d;
    logic                    push, pop, flush;
    logic [15:0]             head;

    assign head = mem_q[rd_ptr_q];

    // Next-state: interpolation FSM, FIFO pointers and registered ready.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        acc_d        = acc_q;
        cur_d        = cur_q;
        delta_d      = delta_q;
        ucnt_d       = ucnt_q;
        frame_tick_d = 1'b0;
        underrun_d   = 1'b0;
        pop          = 1'b0;
        flush        = 1'b0;
        push         = in_valid && in_ready_q;

        unique case (state_q)
            StIdle: begin
                if (enable && (count_q != '0)) begin
                    // First segment ramps up from zero to the first sample.
                    pop          = 1'b1;
                    cur_d        = head;
                    delta_d      = {head[15], head};
                    acc_d        = '0;
                    phase_d      = '0;
                    frame_tick_d = 1'b1;
                    state_d      = StRun;
                end
            end
            StRun: begin
                if (!enable) begin
                    flush   = 1'b1;
                    state_d = StIdle;
                    phase_d = '0;
                    acc_d   = '0;
                    cur_d   = '0;
                    delta_d = '0;
                    ucnt_d  = '0;
                end else if (phase_q != PHASE_LAST) begin
                    phase_d = phase_q + OSR_LOG2'(1);
                    acc_d   = acc_q + {{(ACC_W - 17){delta_q[16]}}, delta_q};
                end else begin
                    // Exact reload at the boundary so rounding never accumulates.
                    phase_d      = '0;
                    acc_d        = {cur_q, {OSR_LOG2{1'b0}}};
                    frame_tick_d = 1'b1;
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        delta_d = $signed({head[15], head}) - $signed({cur_q[15], cur_q});
                        cur_d   = head;
                    end else begin
                        delta_d    = '0;
                        underrun_d = 1'b1;
                        if (ucnt_q != 8'hFF) begin
                            ucnt_d = ucnt_q + 8'd1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            // A push coinciding with the flush is dropped.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
        in_ready_d = (count_d < DEPTH_CNT);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            in_ready_q   <= 1'b0;
            phase_q      <= '0;
            acc_q        <= '0;
            cur_q        <= '0;
            delta_q      <= '0;
            frame_tick_q <= 1'b0;
            underrun_q   <= 1'b0;
            ucnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            in_ready_q   <= in_ready_d;
            phase_q      <= phase_d;
            acc_q        <= acc_d;
            cur_q        <= cur_d;
            delta_q      <= delta_d;
            frame_tick_q <= frame_tick_d;
            underrun_q   <= underrun_d;
            ucnt_q       <= ucnt_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (reset && push && !flush) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_sample   = acc_q[ACC_W-1:OSR_LOG2];
    assign out_valid    = (state_q == StRun);
    assign frame_tick   = frame_tick_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_sd_interp_x128.sv
// Testbench for sd_interp_x128: cycle model built from the segment interpolation
// formula, compared against the DUT every cycle, plus directed constant checks.
module tb_sd_interp_x128;

    logic        clk = 1'b0;
    logic        reset, enable, in_valid, in_ready;
    logic [15:0] in_data, out_sample;
    logic        out_valid, frame_tick, underrun;
    logic [7:0]  underrun_cnt;
    logic [27:0] obs;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sd_interp_x128 #(
        .OSR        (128),
        .OSR_LOG2   (7),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_sample   (out_sample),
        .out_valid    (out_valid),
        .frame_tick   (frame_tick),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    assign obs = {out_sample, out_valid, frame_tick, underrun, underrun_cnt, in_ready};

    // Reference model: segment endpoints (old -> new), position within segment,
    // and a queue standing in for the FIFO.
    int q[$];
    bit m_run, m_ready, m_frame, m_under;
    int m_phase, m_old, m_new, m_ucnt;

    function automatic int floor_div(int num, int den);
        int r;
        r = num / den;
        if ((num % den != 0) && (num < 0)) r = r - 1;
        return r;
    endfunction

    function automatic logic [27:0] exp_vec();
        int s;
        s = m_run ? floor_div(m_old * 128 + m_phase * (m_new - m_old), 128) : 0;
        return {16'(s), m_run, m_frame, m_under, 8'(m_ucnt), m_ready};
    endfunction

    // Advance model by one clock using the current inputs, then the DUT.
    task automatic step();
        bit push;
        int d;
        d = int'($signed(in_data));
        if (!reset) begin
            q.delete();
            m_run = 0; m_ready = 0; m_frame = 0; m_under = 0;
            m_phase = 0; m_old = 0; m_new = 0; m_ucnt = 0;
        end else begin
            push    = in_valid && m_ready;
            m_frame = 0;
            m_under = 0;
            if (m_run && !enable) begin
                q.delete();
                m_run = 0; m_phase = 0; m_old = 0; m_new = 0; m_ucnt = 0;
                push = 0;
            end else if (!m_run) begin
                if (enable && q.size() > 0) begin
                    m_run = 1; m_old = 0; m_new = q.pop_front(); m_phase = 0; m_frame = 1;
                end
            end else if (m_phase < 127) begin
                m_phase++;
            end else begin
                m_phase = 0;
                m_frame = 1;
                m_old   = m_new;
                if (q.size() > 0) begin
                    m_new = q.pop_front();
                end else begin
                    m_under = 1;
                    if (m_ucnt < 255) m_ucnt++;
                end
            end
            if (push) q.push_back(d);
            m_ready = (q.size() < 4);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0; enable = 1'b0; in_valid = 1'b0; in_data = '0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b1; in_valid = 1'b1; in_data = 16'd1234;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset[%0d] got=%h want=%h", i, obs, exp_vec());
            end
        end
        n_tests++;
        if (obs !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h want=%h", obs, 28'h0);
        end
        reset = 1'b1; enable = 1'b0; in_valid = 1'b0;
        step();
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready got=%b want=1", in_ready);
        end
    endtask

    task automatic test_single_ramp();
        apply_reset();
        enable = 1'b1; in_valid = 1'b1; in_data = 16'd12800;
        for (int i = 0; i < 516; i++) begin
            step();
            in_valid = 1'b0;
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL ramp[%0d] got=%h want=%h", i, obs, exp_vec());
            end
            if (i >= 1 && i <= 3) begin
                n_tests++;
                if (out_sample !== 16'((i - 1) * 100)) begin
                    n_fail++;
                    $display("FAIL ramp_start[%0d] got=%0d want=%0d", i, out_sample, (i - 1) * 100);
                end
            end
        end
        n_tests++;
        if (out_sample !== 16'd12800 || underrun_cnt !== 8'd4) begin
            n_fail++;
            $display("FAIL ramp_hold got=%0d/%0d want=12800/4", out_sample, underrun_cnt);
        end
    endtask

    task automatic test_floor_neg();
        apply_reset();
        enable = 1'b1; in_valid = 1'b1; in_data = 16'd0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (i == 0) in_data = 16'hFFFF;
            if (i == 1) in_valid = 1'b0;
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL floor[%0d] got=%h want=%h", i, obs, exp_vec());
            end
            if (i == 129 && out_sample !== 16'h0000) begin
                n_fail++;
                $display("FAIL floor_phase0 got=%h want=0000", out_sample);
            end
            if (i >= 130 && i <= 256 && out_sample !== 16'hFFFF) begin
                n_fail++;
                $display("FAIL floor_neg[%0d] got=%h want=ffff", i, out_sample);
            end
        end
        n_tests++;
    endtask

    task automatic test_full_swing();
        apply_reset();
        enable = 1'b1; in_valid = 1'b1; in_data = 16'h7FFF;
        for (int i = 0; i < 300; i++) begin
            step();
            if (i == 0) in_data = 16'h8000;
            if (i == 1) in_valid = 1'b0;
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL swing[%0d] got=%h want=%h", i, obs, exp_vec());
            end
            if (i == 129 || i == 256 || i == 257) begin
                logic [15:0] want;
                want = (i == 129) ? 16'h7FFF : (i == 256) ? 16'(-32257) : 16'h8000;
                n_tests++;
                if (out_sample !== want) begin
                    n_fail++;
                    $display("FAIL swing_point[%0d] got=%h want=%h", i, out_sample, want);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        int pushes;
        apply_reset();
        enable = 1'b1; in_valid = 1'b1; in_data = 16'($urandom);
        pushes = 0;
        for (int i = 0; i < 1200; i++) begin
            acc = m_ready;
            step();
            if (acc) begin
                pushes++;
                in_data = 16'($urandom);
            end
            n_tests++;
            if (obs !== exp_vec() || underrun !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure[%0d] got=%h want=%h", i, obs, exp_vec());
            end
        end
        // 1 + 4 to fill, then one per 128-cycle segment boundary.
        n_tests++;
        if (pushes < 12 || pushes > 14) begin
            n_fail++;
            $display("FAIL backpressure_pushes got=%0d want=12..14", pushes);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_disable_mid();
        apply_reset();
        enable = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            in_data = 16'(1000 * (i + 1));
            if (i == 4) in_valid = 1'b0;
            step();
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL disable_pre[%0d] got=%h want=%h", i, obs, exp_vec());
            end
        end
        enable = 1'b0; in_valid = 1'b1; in_data = 16'd999;
        step();
        in_valid = 1'b0;
        n_tests++;
        if (obs !== 28'h1) begin
            n_fail++;
            $display("FAIL disable_flush got=%h want=%h", obs, 28'h1);
        end
        enable = 1'b1;
        for (int i = 0; i < 5; i++) step();
        n_tests++;
        if (out_valid !== 1'b0 || out_sample !== 16'd0) begin
            n_fail++;
            $display("FAIL disable_empty got=%b/%h want=0/0000", out_valid, out_sample);
        end
        in_valid = 1'b1; in_data = 16'd12800;
        for (int i = 0; i < 200; i++) begin
            step();
            in_valid = 1'b0;
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL reenable[%0d] got=%h want=%h", i, obs, exp_vec());
            end
            if (i == 3 && out_sample !== 16'd200) begin
                n_fail++;
                $display("FAIL reenable_ramp got=%0d want=200", out_sample);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        enable = 1'b1; in_valid = 1'b1; in_data = 16'd5000;
        for (int i = 0; i < 70; i++) begin
            if (i == 2) in_valid = 1'b0;
            step();
        end
        reset = 1'b0; in_valid = 1'b1; in_data = 16'd777;
        step();
        n_tests++;
        if (obs !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_mid got=%h want=%h", obs, 28'h0);
        end
        reset = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            n_tests++;
            if (obs !== exp_vec() || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_after[%0d] got=%h want=%h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        enable = 1'b1; in_valid = 1'b1; in_data = 16'hF000;
        for (int i = 0; i < 38500; i++) begin
            step();
            in_valid = 1'b0;
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL saturate[%0d] got=%h want=%h", i, obs, exp_vec());
            end
        end
        n_tests++;
        if (underrun_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL saturate_cnt got=%0d want=255", underrun_cnt);
        end
        reset = 1'b0;
        step();
        reset = 1'b1;
        n_tests++;
        if (underrun_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL saturate_reset got=%0d want=0", underrun_cnt);
        end
    endtask

    task automatic test_random();
        apply_reset();
        enable = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            in_valid = ($urandom_range(0, 99) < ((i / 1000) % 2 == 0 ? 1 : 4));
            in_data  = 16'($urandom);
            if ($urandom_range(0, 999) == 0) enable = ~enable;
            step();
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL random[%0d] got=%h want=%h", i, obs, exp_vec());
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; in_valid = 1'b0; in_data = '0;
        test_reset();
        test_single_ramp();
        test_floor_neg();
        test_full_swing();
        test_back_to_back();
        test_disable_mid();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_interp_x128.md
Name: sd_interp_x128

Overview:
- Upstream feeder for the sigma-delta modulator core, running in the modulator's 128x44.1 kHz (5.6448 MHz) clock domain.
- Accepts signed 16-bit PCM samples at the audio rate through a valid/ready handshake and buffers them in a small FIFO.
- Linearly interpolates between consecutive samples, producing one 16-bit sample per clock for the modulator input.
- Reports FIFO underruns.

Parameters:
- OSR, 128, oversampling ratio (clocks per input sample); must be a power of two.
- OSR_LOG2, 7, log2(OSR); accumulator fraction bits.
- FIFO_DEPTH, 4, input FIFO entries (power of two, at least 2).

Ports:
- clk  in  1  global clock, 128x44.1 kHz
- reset  in  1  synchronous, active-low reset
- enable  in  1  run control; low = IDLE, FIFO flushed, output 0
- in_data  in  16  signed PCM sample
- in_valid  in  1  in_data valid
- in_ready  out  1  FIFO can accept; high when count < FIFO_DEPTH
- out_sample  out  16  signed interpolated sample to modulator, one per clk
- out_valid  out  1  high in RUN state
- frame_tick  out  1  one-cycle pulse on the cycle phase becomes 0 (new segment start)
- underrun  out  1  one-cycle pulse when a segment boundary finds the FIFO empty
- underrun_cnt  out  8  saturating count of underruns since reset or since leaving IDLE

Behaviour:
- Reset (reset=0 at a rising edge): state=IDLE, FIFO count=0, phase=0, cur=0, delta=0, acc=0.
- Reset outputs: out_sample=0, out_valid=0, frame_tick=0, underrun=0, underrun_cnt=0, in_ready=0.
- in_ready is registered and is 0 during reset.
- FIFO push: occurs when in_valid && in_ready. There is no bypass; a sample pushed in cycle N is poppable from cycle N+1.
- Simultaneous push and pop leaves count unchanged.
- in_ready is recomputed from the next count each cycle.
- Internal state:
  - acc: signed 16+OSR_LOG2 bits.
  - delta: signed 17 bits (new−old, range −65535..65535).
  - phase: OSR_LOG2 bits.
  - cur: 16 bits, the last loaded sample.
- out_sample = acc[MSB:OSR_LOG2], i.e. floor(acc/OSR). It is a register slice, with no combinational path from inputs.
- IDLE state:
  - Outputs 0; FIFO is pushable.
  - When enable=1 and FIFO is non-empty: pop head.
  - On that pop: cur<=head, delta<=head−0, acc<=0, phase<=0, frame_tick<=1, go to RUN.
  - The waveform ramps from 0 to the first sample.
- RUN state, phase<OSR−1: phase<=phase+1, acc<=acc+delta.
- RUN state, phase==OSR−1 (segment boundary): phase<=0, acc<=cur<<OSR_LOG2 (exact reload, no drift), frame_tick<=1.
  - FIFO non-empty: pop, delta<=head−cur, cur<=head.
  - FIFO empty: delta<=0, cur unchanged (hold), underrun<=1, underrun_cnt increments and saturates at 255.
- Resulting waveform: at phase p of a segment, out_sample = floor((old·OSR + p·(new−old))/OSR). Output stays within [min(old,new), max(old,new)], so no overflow is possible.
- enable=0 in RUN: next cycle goes to IDLE.
  - FIFO flushed (count=0), acc/cur/delta/phase cleared, underrun_cnt cleared.
  - Any push in that same cycle is discarded.
- Reset mid-operation: same effect as power-on reset regardless of state; takes priority over enable and push.
- Latency: a sample in FIFO head at a boundary first influences out_sample 2 cycles later (phase 1).
  - Output at phase 0 equals the previous sample exactly.

Test Plan:
- Reset and enable=1, push one sample 12800 → out_valid rises; out_sample = 0, 100, 200, … at phases 0, 1, 2; then 12800 constant with frame_tick every 128 clocks and underrun pulses; underrun_cnt = 1, 2, 3, ….
- Push 0 then −1 → during the −1 segment, out_sample = 0 at phase 0 and −1 at phases 1..127 (floor rounding toward −inf).
- Push 32767 then −32768 → delta = −65535; out_sample = 32767 at phase 0, −32257 at phase 127, −32768 at the next phase 0; no wrap.
- Source holds in_valid=1 continuously → FIFO fills to 4, in_ready=0; afterwards exactly one push per 128 clocks, coincident with the pop; no sample lost or duplicated; underrun never asserts.
- Deassert enable mid-segment with 3 samples queued → next cycle out_sample=0, out_valid=0, FIFO empty, underrun_cnt=0; re-enable plus a push restarts the ramp from 0.
- Assert reset (low) for 1 cycle mid-segment while in_valid=1 → all outputs at reset values, push ignored; 300 underruns then reset → underrun_cnt shows 255 before, 0 after.
